// File: rtl/sort8_pkg.sv
// sort8_pkg: shared types and constants for the sequential 8-entry sorter.
// Optional build macro: SORT8_SEQ_DESC_EN (descending order, see sort8_cmpx).

package sort8_pkg;

    // Controller states; the top module mirrors these as plain 2-bit constants.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort8_state_t;

    localparam int N_ELEM  = 8;
    localparam int N_PHASE = 8;

    // Odd phases of the transposition schedule use the shifted pairing.
    function automatic logic is_odd_phase(input logic [2:0] ph);
        return ph[0];
    endfunction

endpackage

// File: rtl/sort8_cmpx.sv
// sort8_cmpx: combinational compare-exchange cell.
// lo is the value kept in the left slot, hi the value kept in the right slot.
// Default order is ascending (swap when a > b). With SORT8_SEQ_DESC_EN
// defined the order is descending (swap when a < b). Equal values never
// swap, which keeps the overall sort stable.

module sort8_cmpx #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);

    logic swap;

`ifdef SORT8_SEQ_DESC_EN
    assign swap = (a < b);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/sort8_seq.sv
// sort8_seq: accepts an 8-sample frame over valid/ready, sorts it in place
// with an 8-phase odd-even transposition schedule on four shared
// compare-exchange cells, then streams the result out over valid/ready.
// Optional build macro: SORT8_SEQ_DESC_EN (descending output order).
//
// state | meaning
// ------+--------------------------------------------------------------
// LOAD  | in_ready high (once out of reset); beats fill r[idx]
// SORT  | one compare-exchange phase per cycle, ph = 0..7
// DRAIN | out_valid high; r[idx] presented, idx advances per transfer

module sort8_seq
    import sort8_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam logic [1:0] ST_LOAD  = 2'(LOAD);
    localparam logic [1:0] ST_SORT  = 2'(SORT);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

    localparam logic [2:0] IDX_LAST = 3'(N_ELEM - 1);
    localparam logic [2:0] PH_LAST  = 3'(N_PHASE - 1);

    logic [1:0]    state;
    logic [2:0]    idx;
    logic [2:0]    ph;
    // Holds in_ready low for the cycle right after a reset edge, so the
    // input side only opens once rst_n has been sampled high.
    logic          armed;

    logic [DW-1:0] r      [N_ELEM];
    logic [DW-1:0] r_next [N_ELEM];

    logic [DW-1:0] cx_a  [4];
    logic [DW-1:0] cx_b  [4];
    logic [DW-1:0] cx_lo [4];
    logic [DW-1:0] cx_hi [4];

    logic          odd;
    logic          in_fire;
    logic          out_fire;

    assign odd      = is_odd_phase(ph);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Outputs decode from registered state only.
    assign in_ready  = armed && (state == ST_LOAD);
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (idx == IDX_LAST);
    assign out_data  = out_valid ? r[idx] : '0;
    assign busy      = (state == ST_SORT) || (state == ST_DRAIN);

    // Route register pairs onto the four shared cells by phase parity.
    // Cell 3 has no odd-phase pair; its result is ignored then.
    always_comb begin
        cx_a[0] = r[0];
        cx_b[0] = r[1];
        cx_a[1] = r[2];
        cx_b[1] = r[3];
        cx_a[2] = r[4];
        cx_b[2] = r[5];
        cx_a[3] = r[6];
        cx_b[3] = r[7];
        if (odd) begin
            cx_a[0] = r[1];
            cx_b[0] = r[2];
            cx_a[1] = r[3];
            cx_b[1] = r[4];
            cx_a[2] = r[5];
            cx_b[2] = r[6];
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_cx
        sort8_cmpx #(
            .DW (DW)
        ) u_cmpx (
            .a  (cx_a[k]),
            .b  (cx_b[k]),
            .lo (cx_lo[k]),
            .hi (cx_hi[k])
        );
    end

    // Place cell results back into register slots for the current phase.
    always_comb begin
        r_next[0] = cx_lo[0];
        r_next[1] = cx_hi[0];
        r_next[2] = cx_lo[1];
        r_next[3] = cx_hi[1];
        r_next[4] = cx_lo[2];
        r_next[5] = cx_hi[2];
        r_next[6] = cx_lo[3];
        r_next[7] = cx_hi[3];
        if (odd) begin
            r_next[0] = r[0];
            r_next[1] = cx_lo[0];
            r_next[2] = cx_hi[0];
            r_next[3] = cx_lo[1];
            r_next[4] = cx_hi[1];
            r_next[5] = cx_lo[2];
            r_next[6] = cx_hi[2];
            r_next[7] = r[7];
        end
    end

    // Sample bank: no reset, contents are meaningless until a frame loads.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            if (in_fire) begin
                r[idx] <= in_data;
            end
        end else if (state == ST_SORT) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r[i] <= r_next[i];
            end
        end
    end

    // Controller: frame sequencing, index and phase counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            idx   <= '0;
            ph    <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (idx == IDX_LAST) begin
                            state <= ST_SORT;
                            idx   <= '0;
                            ph    <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_SORT: begin
                    if (ph == PH_LAST) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                        ph    <= '0;
                    end else begin
                        ph <= ph + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (idx == IDX_LAST) begin
                            state <= ST_LOAD;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    idx   <= '0;
                    ph    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort8_seq.sv
// tb_sort8_seq: directed self-checking bench for sort8_seq.
// Expected lists are written in ascending order; a descending build
// (SORT8_SEQ_DESC_EN) reads them back to front.

module tb_sort8_seq;

`ifdef SORT8_SEQ_DESC_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    sort8_seq #(
        .DW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] got [8];
    logic       got_last [8];
    int         n_got;
    int         first_valid_cyc;
    int         last_xfer_cyc;
    int         accept1_cyc;
    int         accept8_cyc;
    int         stall_err;
    int         overlap_err;
    bit         tmo_in;
    bit         tmo_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element 0 goes in the low byte.
    function automatic logic [63:0] pk(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7);
        return {v7, v6, v5, v4, v3, v2, v1, v0};
    endfunction

    task automatic drive_frame(input logic [63:0] frame);
        int guard;
        tmo_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            guard = 0;
            in_valid = 1'b1;
            in_data = frame[8*i +: 8];
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) tmo_in = 1'b1;
            tick();
            if (i == 0) accept1_cyc = cyc;
            if (i == 7) accept8_cyc = cyc;
        end
        in_valid = 1'b0;
        in_data = '0;
    endtask

    // Collects 8 transfers with out_ready following a repeating 4-cycle
    // pattern (bit k%4). With poke set, in_valid is held high meanwhile.
    task automatic collect(input logic [3:0] rdy_pat, input bit poke);
        int k;
        logic prev_stalled;
        logic [7:0] prev_data;
        logic prev_last;
        k = 0;
        prev_stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        n_got = 0;
        first_valid_cyc = -1;
        last_xfer_cyc = -1;
        stall_err = 0;
        overlap_err = 0;
        tmo_out = 1'b0;
        while (n_got < 8 && k < 200) begin
            out_ready = rdy_pat[k % 4];
            if (poke) begin
                in_valid = 1'b1;
                in_data = 8'hAA;
            end
            if (in_ready && out_valid) overlap_err++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stalled && (out_data !== prev_data || out_last !== prev_last)) stall_err++;
            prev_stalled = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                got[n_got] = out_data;
                got_last[n_got] = out_last;
                n_got++;
                if (n_got == 8) last_xfer_cyc = cyc + 1;
            end
            tick();
            k++;
        end
        if (n_got < 8) tmo_out = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        tests_run++;
        if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reverse_frame();
        logic [63:0] exp;
        logic [7:0] e;
        exp = pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        drive_frame(pk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1));
        // SORT fills the 8 cycles after the accept edge; out_valid shows in
        // the 9th cycle, i.e. right after edge E+8.
        collect(4'b1111, 1'b0);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL rev_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        tests_run++;
        if (first_valid_cyc - accept8_cyc !== 8) begin
            tests_failed++;
            $display("FAIL rev_latency: got %0d edges want 8", first_valid_cyc - accept8_cyc);
        end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL rev_data[%0d]: got %h want %h", i, got[i], e); end
            tests_run++;
            if (got_last[i] !== (i == 7)) begin tests_failed++; $display("FAIL rev_last[%0d]: got %b want %b", i, got_last[i], (i == 7)); end
        end
    endtask

    task automatic test_sorted_frame();
        logic [63:0] exp;
        logic [7:0] e;
        exp = pk(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70);
        drive_frame(exp);
        collect(4'b1111, 1'b0);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL sorted_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        tests_run++;
        if (last_xfer_cyc - accept1_cyc + 1 !== 24) begin
            tests_failed++;
            $display("FAIL sorted_frame_cycles: got %0d want 24", last_xfer_cyc - accept1_cyc + 1);
        end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL sorted_data[%0d]: got %h want %h", i, got[i], e); end
        end
    endtask

    task automatic test_duplicates();
        logic [63:0] frame;
        logic [63:0] exp;
        logic [7:0] e;
        logic [7:0] mval [8];
        int mtag [8];
        logic [7:0] tv;
        int tt;
        int j;
        frame = pk(8'd5, 8'd3, 8'd5, 8'd3, 8'hFF, 8'd0, 8'hFF, 8'd0);
        exp = pk(8'd0, 8'd0, 8'd3, 8'd3, 8'd5, 8'd5, 8'hFF, 8'hFF);
        // Sideband model: each sample tagged with its arrival slot, stable
        // insertion sort on the value only.
        for (int i = 0; i < 8; i++) begin
            mval[i] = frame[8*i +: 8];
            mtag[i] = i;
        end
        for (int i = 1; i < 8; i++) begin
            tv = mval[i];
            tt = mtag[i];
            j = i - 1;
            while (j >= 0 && (DESC ? (mval[j] < tv) : (mval[j] > tv))) begin
                mval[j+1] = mval[j];
                mtag[j+1] = mtag[j];
                j--;
            end
            mval[j+1] = tv;
            mtag[j+1] = tt;
        end
        drive_frame(frame);
        collect(4'b1111, 1'b0);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL dup_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL dup_data[%0d]: got %h want %h", i, got[i], e); end
            tests_run++;
            if (got[i] !== mval[i]) begin
                tests_failed++;
                $display("FAIL dup_model[%0d]: got %h want %h (tag %0d)", i, got[i], mval[i], mtag[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        logic [7:0] e;
        exp = pk(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80);
        drive_frame(pk(8'h20, 8'h80, 8'h10, 8'h70, 8'h30, 8'h60, 8'h40, 8'h50));
        collect(4'b1001, 1'b1);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL bp_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        tests_run++;
        if (stall_err !== 0) begin tests_failed++; $display("FAIL bp_stall_hold: got %0d changes want 0", stall_err); end
        tests_run++;
        if (overlap_err !== 0) begin tests_failed++; $display("FAIL bp_ready_overlap: got %0d cycles want 0", overlap_err); end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL bp_data[%0d]: got %h want %h", i, got[i], e); end
            tests_run++;
            if (got_last[i] !== (i == 7)) begin tests_failed++; $display("FAIL bp_last[%0d]: got %b want %b", i, got_last[i], (i == 7)); end
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] exp;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 8'hE0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_release: got %b want 1", in_ready); end
        exp = pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9);
        drive_frame(pk(8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4));
        collect(4'b1111, 1'b0);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL midrst_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL midrst_data[%0d]: got %h want %h", i, got[i], e); end
        end
    endtask

    task automatic test_order_build();
        logic [63:0] exp;
        logic [7:0] e;
        exp = pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        drive_frame(exp);
        collect(4'b1111, 1'b0);
        tests_run++;
        if (tmo_in || tmo_out) begin tests_failed++; $display("FAIL order_timeout: in=%b out=%b want 0 0", tmo_in, tmo_out); end
        for (int i = 0; i < 8; i++) begin
            e = DESC ? exp[8*(7-i) +: 8] : exp[8*i +: 8];
            tests_run++;
            if (got[i] !== e) begin tests_failed++; $display("FAIL order_data[%0d]: got %h want %h", i, got[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_reverse_frame();
        test_sorted_frame();
        test_duplicates();
        test_backpressure();
        test_mid_reset();
        test_order_build();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1);
    end

endmodule
